valu_fadd_arbiter: RTL



---
 rtl/valu_fadd_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/valu_fadd_arbiter.sv
// Shares one combinational float adder among N_REQ lanes, granting them round-robin and running one operation at a time.
// Operands are held ADD_LAT cycles; the result appears ADD_LAT+1 cycles after the grant cycle. Optional sticky flags: VALU_FADD_ARB_STICKY_EN.
module valu_fadd_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [31:0]          fadd_a,
    output logic [31:0]          fadd_b,
    input  logic [31:0]          fadd_out,
    input  logic                 fadd_nan,
    input  logic                 fadd_ovf,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_data,
    output logic                 resp_nan,
    output logic                 resp_ovf,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
`ifdef VALU_FADD_ARB_STICKY_EN
    ,
    input  logic                 clr_sticky,
    output logic                 sticky_nan,
    output logic                 sticky_ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      fadd_a_q, fadd_a_d;
    logic [31:0]      fadd_b_q, fadd_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_nan_q, resp_nan_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;

    logic [N_REQ-1:0] gnt_oh;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [31:0]      sel_a, sel_b;
    logic             capture;

    // Round-robin search: candidate k is (last+1+k) mod N_REQ, first valid wins.
    always_comb begin
        int pos;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(last_q) + 1 + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!gnt_any && req_valid[i] && (pos == i)) begin
                    gnt_any   = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = ID_W'(i);
                    sel_a     = req_a[32*i +: 32];
                    sel_b     = req_b[32*i +: 32];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE && !rst) ? gnt_oh : '0;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        fadd_a_d     = fadd_a_q;
        fadd_b_d     = fadd_b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_nan_d   = resp_nan_q;
        resp_ovf_d   = resp_ovf_q;
        resp_id_d    = resp_id_q;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    fadd_a_d  = sel_a;
                    fadd_b_d  = sel_b;
                    resp_id_d = gnt_idx;
                    last_d    = gnt_idx;
                    cnt_d     = 4'(ADD_LAT - 1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    capture      = 1'b1;
                    resp_data_d  = fadd_out;
                    resp_nan_d   = fadd_nan;
                    resp_ovf_d   = fadd_ovf;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= ID_W'(N_REQ - 1);
            cnt_q        <= '0;
            fadd_a_q     <= '0;
            fadd_b_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_nan_q   <= 1'b0;
            resp_ovf_q   <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            fadd_a_q     <= fadd_a_d;
            fadd_b_q     <= fadd_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_nan_q   <= resp_nan_d;
            resp_ovf_q   <= resp_ovf_d;
            resp_id_q    <= resp_id_d;
        end
    end

`ifdef VALU_FADD_ARB_STICKY_EN
    logic sticky_nan_q, sticky_nan_d;
    logic sticky_ovf_q, sticky_ovf_d;

    // A clear on the capture edge takes precedence over new flags.
    always_comb begin
        sticky_nan_d = sticky_nan_q;
        sticky_ovf_d = sticky_ovf_q;
        if (clr_sticky) begin
            sticky_nan_d = 1'b0;
            sticky_ovf_d = 1'b0;
        end else if (capture) begin
            sticky_nan_d = sticky_nan_q | fadd_nan;
            sticky_ovf_d = sticky_ovf_q | fadd_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_nan_q <= 1'b0;
            sticky_ovf_q <= 1'b0;
        end else begin
            sticky_nan_q <= sticky_nan_d;
            sticky_ovf_q <= sticky_ovf_d;
        end
    end

    assign sticky_nan = sticky_nan_q;
    assign sticky_ovf = sticky_ovf_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

    assign fadd_a     = fadd_a_q;
    assign fadd_b     = fadd_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_nan   = resp_nan_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_id    = resp_id_q;
    assign busy       = (state_q != IDLE);

endmodule
